// File: rtl/pager_tlb.sv
// Banked page table with hardware sweep engine.
// Translates a VPN to PPN plus flags and flags page failures.
module pager_tlb #(
  parameter int VPN_W      = 9,
  parameter int PPN_W      = 11,
  parameter int BANKS      = 2,
  parameter int AUTO_SWEEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             lkEN,
  input  logic [VPN_W-1:0] lkVPN,
  input  logic             lkUSER,
  input  logic             lkWRITE,
  input  logic             wrEN,
  input  logic [VPN_W-1:0] wrVPN,
  input  logic             wrVALID,
  input  logic             wrWRITEABLE,
  input  logic             wrCACHEABLE,
  input  logic             wrUSER,
  input  logic [PPN_W-1:0] wrPPN,
  input  logic             sweepREQ,
  output logic             pageVALID,
  output logic             pageWRITEABLE,
  output logic             pageCACHEABLE,
  output logic             pageUSER,
  output logic [PPN_W-1:0] pageADDR,
  output logic             pageFAIL,
  output logic             pageWRFAIL,
  output logic             sweepBUSY,
  output logic             sweepDONE
);

  localparam int BW    = $clog2(BANKS);
  localparam int ROW_W = VPN_W - BW;
  localparam int CNT_W = (ROW_W > 0) ? ROW_W : 1;
  localparam int BNK_W = (BW > 0) ? BW : 1;
  localparam int ROWS  = 2 ** ROW_W;

  typedef struct packed {
    logic             valid;
    logic             writeable;
    logic             cacheable;
    logic             user;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             last;
  logic [BNK_W-1:0] wr_bank;
  logic [BNK_W-1:0] lk_bank;
  logic [CNT_W-1:0] wr_row;
  logic [CNT_W-1:0] lk_row;
  entry_t           wr_ent;
  entry_t           lk_ent;
  logic             lk_fail;
  logic             lk_wrfail;

  entry_t mem [BANKS][ROWS];

  generate
    if (BW == 0) begin : g_one_bank
      assign wr_bank = '0;
      assign lk_bank = '0;
    end else begin : g_banks
      assign wr_bank = wrVPN[BW-1:0];
      assign lk_bank = lkVPN[BW-1:0];
    end
    if (ROW_W == 0) begin : g_one_row
      assign wr_row = '0;
      assign lk_row = '0;
    end else begin : g_rows
      assign wr_row = wrVPN[VPN_W-1:BW];
      assign lk_row = lkVPN[VPN_W-1:BW];
    end
  endgenerate

  assign busy   = (state == S_BUSY);
  assign last   = (cnt == CNT_W'(ROWS - 1));
  assign wr_ent = '{wrVALID, wrWRITEABLE, wrCACHEABLE,
                    wrUSER, wrPPN};
  assign lk_ent = mem[lk_bank][lk_row];

  assign lk_wrfail = lk_ent.valid & (lk_ent.user == lkUSER)
                   & lkWRITE & ~lk_ent.writeable;
  assign lk_fail   = ~lk_ent.valid | (lk_ent.user != lkUSER)
                   | (lkWRITE & ~lk_ent.writeable);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nx;
  end

  // INIT exists only to launch the post-reset auto sweep.
  always_comb begin
    state_nx = state;
    if (clken) begin
      unique case (state)
        S_INIT:  state_nx = (AUTO_SWEEP != 0 || sweepREQ)
                          ? S_BUSY : S_IDLE;
        S_BUSY:  state_nx = last ? S_DONE : S_BUSY;
        default: state_nx = sweepREQ ? S_BUSY : S_IDLE;
      endcase
    end
  end

  always_comb begin
    sweepBUSY = (state == S_BUSY);
    sweepDONE = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clken && busy)
      cnt <= last ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clken) begin
      if (busy) begin
        for (int b = 0; b < BANKS; b++)
          mem[b][cnt] <= '0;
      end else if (wrEN) begin
        mem[wr_bank][wr_row] <= wr_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pageVALID     <= 1'b0;
      pageWRITEABLE <= 1'b0;
      pageCACHEABLE <= 1'b0;
      pageUSER      <= 1'b0;
      pageADDR      <= '0;
      pageFAIL      <= 1'b0;
      pageWRFAIL    <= 1'b0;
    end else if (clken && lkEN) begin
      if (busy) begin
        pageVALID     <= 1'b0;
        pageWRITEABLE <= 1'b0;
        pageCACHEABLE <= 1'b0;
        pageUSER      <= 1'b0;
        pageADDR      <= '0;
        pageFAIL      <= 1'b1;
        pageWRFAIL    <= 1'b0;
      end else if (!wrEN) begin
        pageVALID     <= lk_ent.valid;
        pageWRITEABLE <= lk_ent.writeable;
        pageCACHEABLE <= lk_ent.cacheable;
        pageUSER      <= lk_ent.user;
        pageADDR      <= lk_ent.ppn;
        pageFAIL      <= lk_fail;
        pageWRFAIL    <= lk_wrfail;
      end
    end
  end

endmodule

// File: doc/pager_tlb.md
Name: pager_tlb

Overview:
- Parametrised successor to the KS10 page table.
- Translates a VPN_W-bit virtual page number into a PPN_W-bit physical page number plus flags, and flags page failures: invalid, user/exec mismatch, write to a non-writeable page.
- Adds a self-timed hardware sweep engine that clears BANKS entries per cycle and reports busy/done, replacing the microcode-driven sweep.
- Sits between the VMA load path and the memory bus interface in the CPU.

Parameters:
- VPN_W, 9: virtual page number width; table depth is 2**VPN_W entries.
- PPN_W, 11: physical page number width.
- BANKS, 2: interleave factor and entries cleared per sweep cycle; power of two, 1..2**VPN_W.
- AUTO_SWEEP, 1: when 1, a sweep starts automatically on the first enabled cycle after reset release.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clken  in  1  clock enable; all state advances only when high.
- lkEN  in  1  lookup request.
- lkVPN  in  VPN_W  lookup virtual page.
- lkUSER  in  1  lookup is a user-mode access.
- lkWRITE  in  1  lookup is a write access.
- wrEN  in  1  table write request.
- wrVPN  in  VPN_W  write virtual page.
- wrVALID, wrWRITEABLE, wrCACHEABLE, wrUSER  in  1 each  entry flags to store.
- wrPPN  in  PPN_W  physical page to store.
- sweepREQ  in  1  start a sweep.
- pageVALID, pageWRITEABLE, pageCACHEABLE, pageUSER  out  1 each  flags from the last lookup.
- pageADDR  out  PPN_W  physical page from the last lookup.
- pageFAIL  out  1  last lookup failed.
- pageWRFAIL  out  1  last lookup failed solely on write protection.
- sweepBUSY  out  1  sweep in progress.
- sweepDONE  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (asynchronous, rst low):
  - All outputs clear to 0; sweep counter clears to 0.
  - Table contents are not cleared by reset.
  - With AUTO_SWEEP=1, the first clken cycle after release sets sweepBUSY=1.
  - rst asserted mid-sweep aborts the sweep; with AUTO_SWEEP=1 it restarts from entry 0 after release.
- Storage: 2**VPN_W entries of (VALID, WRITEABLE, CACHEABLE, USER, PPN), organised as BANKS banks.
  - Bank select is VPN[low log2(BANKS) bits].
  - Row is the remaining high bits.
- Priority per clken cycle: sweep step > write > lookup.
- Sweep:
  - A sweepREQ while idle sets sweepBUSY the next cycle.
  - Each busy cycle zeroes row cnt in every bank, then cnt increments.
  - Duration is 2**VPN_W/BANKS busy cycles.
  - sweepBUSY drops and sweepDONE pulses high for exactly one clken cycle after the final row.
  - sweepREQ while busy is ignored; no restart.
  - While busy, wrEN is ignored.
  - While busy, a lookup produces all flags 0, pageADDR 0, pageFAIL=1, pageWRFAIL=0.
- Write: the entry at wrVPN is updated the same edge. Other entries are untouched.
- Write and lookup in the same cycle: the write is performed, the lookup is dropped, and all lookup outputs hold their previous values.
- Lookup: latency is 1 cycle; outputs register on the edge where lkEN&clken and neither sweep nor write is active. Outputs hold until the next accepted lookup.
  - pageFAIL = !VALID | (USER != lkUSER) | (lkWRITE & !WRITEABLE).
  - pageWRFAIL = VALID & (USER == lkUSER) & lkWRITE & !WRITEABLE.
  - Flags and pageADDR report the stored entry even when the lookup fails.
- clken low: no state changes, including the sweep counter and sweepDONE. A pending DONE pulse is held until the next clken cycle.
- Sweep counter width is VPN_W-log2(BANKS), with terminal count at all-ones. When BANKS equals the depth, a sweep is one cycle.

Test Plan:
- Reset release, AUTO_SWEEP=1, VPN_W=9, BANKS=2, clken=1 -> sweepBUSY high 256 cycles, sweepDONE single pulse, then a lookup of VPN 0x1FF returns pageFAIL=1, pageVALID=0.
- Write VPN 0x055 {V=1,W=1,C=1,U=1,PPN=0x5A3}; lookup VPN 0x055 user read -> next cycle pageADDR=0x5A3, flags 1111, pageFAIL=0. Lookup VPN 0x054 -> pageFAIL=1, confirming no bank aliasing.
- Write VPN 0x010 {V=1,W=0,U=0}; exec write lookup -> pageFAIL=1, pageWRFAIL=1. Exec read -> pageFAIL=0. User read -> pageFAIL=1, pageWRFAIL=0.
- Populate 8 entries, pulse sweepREQ; issue wrEN and lookups mid-sweep and a second sweepREQ -> writes ignored, lookups fail, sweep still 256 cycles. All 8 entries invalid afterward.
- Assert rst at sweep cycle 100, release -> counter restarts; sweepDONE only after 256 further busy cycles.
- Toggle clken 1-of-3 during a sweep -> sweep spans 768 clocks, sweepDONE high for 3 clocks (one enabled cycle). Same-cycle wrEN+lkEN -> write lands, lookup outputs unchanged.
